// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce block: FSM state encodings and
// glitch counter width.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_e;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; chain resets to INIT.
module sync_ff #(
  parameter int STAGES = 2,
  parameter bit INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{INIT}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce.sv
// Synchronise a raw input and accept a new level only after STABLE_CYCLES
// consecutive samples. Define DEBOUNCE_GLITCH_COUNT_EN to add glitch_count.
module debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 12000,
  parameter int SYNC_STAGES   = 2,
  parameter bit INIT          = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  output logic                out,
  output logic                rise,
  output logic                fall
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_count
`endif
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic          s;
  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          out_n, rise_n, fall_n;

  sync_ff #(.STAGES(SYNC_STAGES), .INIT(INIT)) u_sync (
    .clk(clk), .rst(rst), .d(in), .q(s)
  );

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT ? ST_STABLE_HI : ST_STABLE_LO;
      cnt   <= '0;
      out   <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out   <= out_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    out_n   = out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_STABLE_LO: begin
        cnt_n = '0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_n = ST_STABLE_HI;
            out_n   = 1'b1;
            rise_n  = 1'b1;
          end else begin
            state_n = ST_WAIT_HI;
            cnt_n   = CW'(1);
          end
        end
      end
      ST_WAIT_HI: begin
        if (!s) begin
          state_n = ST_STABLE_LO;
          cnt_n   = '0;
        end else if (cnt_inc == CMAX) begin
          state_n = ST_STABLE_HI;
          cnt_n   = '0;
          out_n   = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_STABLE_HI: begin
        cnt_n = '0;
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_n = ST_STABLE_LO;
            out_n   = 1'b0;
            fall_n  = 1'b1;
          end else begin
            state_n = ST_WAIT_LO;
            cnt_n   = CW'(1);
          end
        end
      end
      ST_WAIT_LO: begin
        if (s) begin
          state_n = ST_STABLE_HI;
          cnt_n   = '0;
        end else if (cnt_inc == CMAX) begin
          state_n = ST_STABLE_LO;
          cnt_n   = '0;
          out_n   = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = ST_STABLE_LO;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  // An abort is a WAIT state seeing the old level again before acceptance.
  logic abort;
  assign abort = (state == ST_WAIT_HI && !s) || (state == ST_WAIT_LO && s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      glitch_count <= '0;
    else if (abort && glitch_count != {GLITCH_W{1'b1}})
      glitch_count <= glitch_count + GLITCH_W'(1);
  end
`endif

endmodule

// File: tb/tb_debounce.sv
// Randomised and directed check of debounce against a sliding-window model;
// a second instance (INIT=1, STABLE_CYCLES=1) is checked alongside.
module tb_debounce;

  localparam int SS   = 2;
  localparam int SC   = 8;
  localparam bit INIT = 1'b0;

  logic clk = 1'b0, rst = 1'b1, in = 1'b0;
  logic out, rise, fall, out1, rise1, fall1;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] gc, gc1;
`endif

  int nchk = 0, npass = 0;

  always #5 clk = ~clk;

  debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .rise(rise), .fall(fall)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    , .glitch_count(gc)
`endif
  );

  debounce #(.STABLE_CYCLES(1), .SYNC_STAGES(SS), .INIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in(in), .out(out1), .rise(rise1), .fall(fall1)
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    , .glitch_count(gc1)
`endif
  );

  task automatic check(input string nm, input int a, input int e);
    nchk++;
    if (a == e) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
  endtask

  // ---------------- reference model ----------------
  // out flips once the last SC synchronised samples all disagree with it;
  // a glitch is a run of disagreeing samples that ends before that.
  bit ih[SS], ih1[SS], wh[SC];
  bit ms, ms1, mall, prev_s, mo, mr, mf, m1o, m1r, m1f;
  int mg, ecnt, rise_edge, fall_edge;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SS; i++) begin ih[i] = INIT; ih1[i] = 1'b1; end
      for (int i = 0; i < SC; i++) wh[i] = INIT;
      prev_s = INIT; mo = INIT; mr = 0; mf = 0;
      m1o = 1'b1; m1r = 0; m1f = 0;
      mg = 0; ecnt = 0; rise_edge = -1; fall_edge = -1;
    end else begin
      ecnt++;
      ms  = ih[SS-1];
      ms1 = ih1[SS-1];
      for (int i = SS-1; i > 0; i--) begin ih[i] = ih[i-1]; ih1[i] = ih1[i-1]; end
      ih[0] = in; ih1[0] = in;
      for (int i = SC-1; i > 0; i--) wh[i] = wh[i-1];
      wh[0] = ms;
      mall = 1'b1;
      for (int i = 0; i < SC; i++) if (wh[i] == mo) mall = 1'b0;
      mr = 0; mf = 0;
      if (ms == mo && prev_s != mo && mg < 255) mg++;
      if (mall) begin
        mo = !mo; mr = mo; mf = !mo;
        if (mo) rise_edge = ecnt; else fall_edge = ecnt;
      end
      prev_s = ms;
      m1r = ms1 & !m1o; m1f = !ms1 & m1o; m1o = ms1;
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("out", out, mo);
      check("rise", rise, mr);
      check("fall", fall, mf);
      check("out1", out1, m1o);
      check("rise1", rise1, m1r);
      check("fall1", fall1, m1f);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
      check("glitch_count", gc, mg);
      check("glitch_count1", gc1, 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Observe n edges (edge 1 = next posedge); drop in to 0 after edge drop_at.
  task automatic obs(input int n, input int drop_at, input int sel,
                     output int hi, output int re, output int fe);
    hi = 0; re = -1; fe = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? out : out1) hi++;
      if ((sel == 0) ? rise : rise1) if (re < 0) re = k;
      if ((sel == 0) ? fall : fall1) if (fe < 0) fe = k;
      if (k == drop_at) in = 1'b0;
    end
    #1;
  endtask

  int hi, re, fe, base;

  initial begin
    rst = 1'b1; in = 1'b0;
    step(3);
    check("reset_out", out, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    check("reset_out1", out1, 1);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("reset_gc", gc, 0);
`endif
    rst = 1'b0;
    // INIT=1, STABLE_CYCLES=1 instance sees in=0 right after release
    obs(6, 0, 1, hi, re, fe);
    check("u1_fall_edge", fe, 3);

    // clean step
    base = ecnt; in = 1'b1;
    obs(50, 0, 0, hi, re, fe);
    check("clean_rise_edge", re, 10);
    check("clean_no_fall", fe, -1);
    check("model_rise_edge", rise_edge - base, 10);
    in = 1'b0; step(20);

    // glitch of SC-1 samples
    in = 1'b1;
    obs(30, 7, 0, hi, re, fe);
    check("glitch_no_rise", re, -1);
    check("glitch_out_low", hi, 0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("glitch_count_1", gc, 1);
`endif

    // exactly SC samples
    in = 1'b1;
    obs(30, 8, 0, hi, re, fe);
    check("boundary_rise_edge", re, 10);
    check("boundary_fall_edge", fe, 18);
    check("boundary_high_cycles", hi, 8);

    // async reset while waiting to fall
    in = 1'b1; step(15);
    in = 1'b0; step(5);
    check("pre_reset_out", out, 1);
    @(posedge clk); #4;
    in = 1'b1; rst = 1'b1; #1;
    check("async_out", out, 0);
    check("async_fall", fall, 0);
    check("async_rise", rise, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    obs(20, 0, 0, hi, re, fe);
    check("post_reset_rise_edge", re, 10);
    in = 1'b0; step(20);

    // repeated short glitches
    repeat (300) begin
      in = 1'b1; step(3);
      in = 1'b0; step(3);
    end
    step(5);
    check("glitch_storm_out", out, 0);
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    check("glitch_saturate", gc, 255);
`endif

    // toggling every cycle never moves out
    in = 1'b1; step(20);
    repeat (200) begin in = ~in; step(1); end
    check("toggle_out_held", out, 1);
    in = 1'b1; step(5);

    // randomised levels and hold times, occasional reset
    repeat (400) begin
      in = 1'($urandom_range(0, 1));
      step($urandom_range(1, 12));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; step(1);
        rst = 1'b0;
      end
    end
    step(20);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
